// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared frame layout and deserializer state encodings
package router_pkg;

  localparam int RECV_DATA_WIDTH    = 1024;
  localparam int HOST_PAYLOAD_WIDTH = 64 - 3;
  localparam int NUMBER_PACKET      = RECV_DATA_WIDTH / HOST_PAYLOAD_WIDTH + 1;

  localparam int HDR_FLAG_BIT = 0;
  localparam int ROUTER_LSB   = 1;
  localparam int TTL_LSB      = 3;
  localparam int DST_LSB      = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } deser_state_t;

endpackage

// File: rtl/deserializer.sv
// rtl/deserializer.sv - Aurora RX beat stream to 1024-bit frame reassembly
module deserializer #(
  parameter int NUMER_OF_LANE          = 1,
  parameter int AURORA_DATA_WIDTH      = 64 * NUMER_OF_LANE,
  parameter int RECV_DATA_WIDTH        = router_pkg::RECV_DATA_WIDTH,
  parameter int RECOGNIZE_HEADER_WIDTH = 1,
  parameter int RECOGNIZE_ROUTER_WIDTH = 2,
  parameter int HOST_PAYLOAD_WIDTH     = router_pkg::HOST_PAYLOAD_WIDTH,
  parameter int NUMBER_PACKET          = router_pkg::NUMBER_PACKET,
  parameter int ADDR_WIDTH             = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              axis_rx_tvalid,
  input  logic                              axis_rx_tlast,
  input  logic [AURORA_DATA_WIDTH-1:0]      axis_rx_tdata,
  output logic                              recv_data_valid,
  output logic [RECV_DATA_WIDTH-1:0]        v_data_recv,
  output logic [ADDR_WIDTH-1:0]             dst_addr_recv,
  output logic [1:0]                        TTL_recv,
  output logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id_recv,
  output logic                              frame_error
);
  import router_pkg::*;

  localparam int CNT_W    = $clog2(NUMBER_PACKET + 1);
  localparam int PAY_LSB  = RECOGNIZE_HEADER_WIDTH + RECOGNIZE_ROUTER_WIDTH;
  localparam int SHADOW_W = (NUMBER_PACKET - 1) * HOST_PAYLOAD_WIDTH;
  localparam int LAST_W   = RECV_DATA_WIDTH - SHADOW_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUMBER_PACKET);

  deser_state_t state, next_state;

  logic [CNT_W-1:0]                  beat_cnt;
  logic [SHADOW_W-1:0]               shadow;
  logic [ADDR_WIDTH-1:0]             sh_dst;
  logic [1:0]                        sh_ttl;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0] sh_router;

  logic                              is_hdr;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0] beat_router;
  logic                              latch_hdr, store, complete, err;

  assign is_hdr      = axis_rx_tdata[HDR_FLAG_BIT];
  assign beat_router = axis_rx_tdata[ROUTER_LSB +: RECOGNIZE_ROUTER_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    latch_hdr  = 1'b0;
    store      = 1'b0;
    complete   = 1'b0;
    err        = 1'b0;
    if (axis_rx_tvalid) begin
      case (state)
        PAYLOAD: begin
          if (is_hdr) begin
            err       = 1'b1;
            latch_hdr = 1'b1;
          end else if (beat_router != sh_router) begin
            err        = 1'b1;
            next_state = axis_rx_tlast ? IDLE : DROP;
          end else if (beat_cnt != LAST_CNT) begin
            if (axis_rx_tlast) begin
              err        = 1'b1;
              next_state = IDLE;
            end else begin
              store = 1'b1;
            end
          end else if (!axis_rx_tlast) begin
            err        = 1'b1;
            next_state = DROP;
          end else begin
            complete   = 1'b1;
            next_state = IDLE;
          end
        end
        default: begin
          // IDLE and DROP treat a header beat identically
          if (is_hdr) begin
            if (axis_rx_tlast) begin
              err        = 1'b1;
              next_state = IDLE;
            end else begin
              latch_hdr  = 1'b1;
              next_state = PAYLOAD;
            end
          end else if (state == IDLE) begin
            err        = 1'b1;
            next_state = axis_rx_tlast ? IDLE : DROP;
          end else if (axis_rx_tlast) begin
            next_state = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt        <= '0;
      shadow          <= '0;
      sh_dst          <= '0;
      sh_ttl          <= '0;
      sh_router       <= '0;
      recv_data_valid <= 1'b0;
      frame_error     <= 1'b0;
      v_data_recv     <= '0;
      dst_addr_recv   <= '0;
      TTL_recv        <= '0;
      router_id_recv  <= '0;
    end else begin
      recv_data_valid <= complete;
      frame_error     <= err;
      if (latch_hdr) begin
        sh_dst    <= axis_rx_tdata[DST_LSB +: ADDR_WIDTH];
        sh_ttl    <= axis_rx_tdata[TTL_LSB +: 2];
        sh_router <= beat_router;
        beat_cnt  <= CNT_W'(1);
      end
      if (store) begin
        for (int k = 1; k < NUMBER_PACKET; k++) begin
          if (beat_cnt == CNT_W'(k))
            shadow[k*HOST_PAYLOAD_WIDTH-1 -: HOST_PAYLOAD_WIDTH] <=
              axis_rx_tdata[PAY_LSB +: HOST_PAYLOAD_WIDTH];
        end
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      // The short final slice goes straight to the output, never through the shadow
      if (complete) begin
        v_data_recv    <= {axis_rx_tdata[PAY_LSB +: LAST_W], shadow};
        dst_addr_recv  <= sh_dst;
        TTL_recv       <= sh_ttl;
        router_id_recv <= sh_router;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed scoreboard bench for deserializer
module tb_deserializer;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           tvalid = 1'b0;
  logic           tlast = 1'b0;
  logic [63:0]    tdata = '0;
  logic           recv_data_valid;
  logic [1023:0]  v_data_recv;
  logic [9:0]     dst_addr_recv;
  logic [1:0]     TTL_recv;
  logic [1:0]     router_id_recv;
  logic           frame_error;

  deserializer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .axis_rx_tvalid  (tvalid),
    .axis_rx_tlast   (tlast),
    .axis_rx_tdata   (tdata),
    .recv_data_valid (recv_data_valid),
    .v_data_recv     (v_data_recv),
    .dst_addr_recv   (dst_addr_recv),
    .TTL_recv        (TTL_recv),
    .router_id_recv  (router_id_recv),
    .frame_error     (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1023:0] data;
    logic [9:0]    dst;
    logic [1:0]    ttl;
    logic [1:0]    rid;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  int last_accept = 0;
  int lt = 0;
  logic [1023:0] va, vb, vc, vd, ones;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    int w;
    w = 0;
    for (int i = 15; i >= 0; i--)
      if (got[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s word%0d got=%h exp=%h", tag, w, got[w*64 +: 64], exp[w*64 +: 64]);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_error) err_cnt <= err_cnt + 1;
      if (recv_data_valid) begin
        valid_cnt      <= valid_cnt + 1;
        prev_valid_cyc <= last_valid_cyc;
        last_valid_cyc <= cyc;
        if (sb.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          chk_wide("v_data_recv", v_data_recv, sb[0].data);
          chk("dst_addr_recv", 64'(dst_addr_recv), 64'(sb[0].dst));
          chk("TTL_recv", 64'(TTL_recv), 64'(sb[0].ttl));
          chk("router_id_recv", 64'(router_id_recv), 64'(sb[0].rid));
          void'(sb.pop_front());
        end
      end
    end
  end

  function automatic logic [63:0] hdr_w(input logic [9:0] dst, input logic [1:0] ttl,
                                        input logic [1:0] rid);
    return {49'd0, dst, ttl, rid, 1'b1};
  endfunction

  function automatic logic [63:0] pay_w(input logic [1:0] rid, input logic [60:0] s);
    return {s, rid, 1'b0};
  endfunction

  // Beat 17 carries 48 payload bits; the unused top bits are filled with junk
  function automatic logic [60:0] slice(input logic [1023:0] v, input int k);
    if (k < 17) return v[k*61-1 -: 61];
    return {13'h1555, v[1023:976]};
  endfunction

  function automatic logic [1023:0] rand_vec();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic beat(input logic last, input logic [63:0] d);
    tvalid = 1'b1;
    tlast  = last;
    tdata  = d;
    @(posedge clk);
    #1;
    last_accept = cyc;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [1023:0] v, input logic [9:0] dst,
                            input logic [1:0] ttl, input logic [1:0] rid);
    exp_t e;
    e.data = v; e.dst = dst; e.ttl = ttl; e.rid = rid;
    sb.push_back(e);
    beat(1'b0, hdr_w(dst, ttl, rid));
    for (int k = 1; k <= 17; k++) beat(k == 17, pay_w(rid, slice(v, k)));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk_wide({tag, "_v_data"}, v_data_recv, '0);
    chk({tag, "_dst"}, 64'(dst_addr_recv), 64'd0);
    chk({tag, "_ttl"}, 64'(TTL_recv), 64'd0);
    chk({tag, "_rid"}, 64'(router_id_recv), 64'd0);
    chk({tag, "_valid"}, 64'(recv_data_valid), 64'd0);
    chk({tag, "_err"}, 64'(frame_error), 64'd0);
  endtask

  initial begin
    va   = {16{64'hA5A5_5A5A_0F0F_F0F0}};
    ones = '1;
    vb   = rand_vec();
    vc   = rand_vec();
    vd   = rand_vec();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Loopback reference frame
    send_frame(va, 10'h2AB, 2'b10, 2'b01);
    lt = last_accept;
    idle(3);
    chk("t1_valid_cnt", 64'(valid_cnt), 64'd1);
    chk("t1_latency", 64'(last_valid_cyc), 64'(lt));
    chk("t1_err_cnt", 64'(err_cnt), 64'd0);
    chk_wide("t1_hold", v_data_recv, va);

    // Back-to-back frames, zero gap
    send_frame('0, 10'h155, 2'b01, 2'b10);
    send_frame(ones, 10'h3FF, 2'b11, 2'b11);
    idle(3);
    chk("t2_valid_cnt", 64'(valid_cnt), 64'd3);
    chk("t2_spacing", 64'(last_valid_cyc - prev_valid_cyc), 64'd18);
    chk("t2_err_cnt", 64'(err_cnt), 64'd0);

    // Early tlast on payload beat 5
    beat(1'b0, hdr_w(10'h0AA, 2'b01, 2'b01));
    for (int k = 1; k <= 5; k++) beat(k == 5, pay_w(2'b01, slice(vb, k)));
    idle(3);
    chk("t3_err_cnt", 64'(err_cnt), 64'd1);
    chk("t3_valid_cnt", 64'(valid_cnt), 64'd3);
    chk_wide("t3_v_data_kept", v_data_recv, ones);
    chk("t3_dst_kept", 64'(dst_addr_recv), 64'h3FF);

    // Router id mismatch on beat 4, remainder dropped, then a good frame
    beat(1'b0, hdr_w(10'h011, 2'b00, 2'b01));
    for (int k = 1; k <= 17; k++)
      beat(k == 17, pay_w((k == 4) ? 2'b11 : 2'b01, slice(vc, k)));
    idle(2);
    chk("t4_err_cnt", 64'(err_cnt), 64'd2);
    chk("t4_valid_cnt", 64'(valid_cnt), 64'd3);
    send_frame(vb, 10'h3C5, 2'b00, 2'b01);
    idle(3);
    chk("t4_good_valid_cnt", 64'(valid_cnt), 64'd4);
    chk("t4_good_err_cnt", 64'(err_cnt), 64'd2);

    // Header arrives at beat 9 of a frame
    beat(1'b0, hdr_w(10'h100, 2'b01, 2'b10));
    for (int k = 1; k <= 8; k++) beat(1'b0, pay_w(2'b10, slice(vd, k)));
    send_frame(vc, 10'h0F7, 2'b11, 2'b00);
    lt = last_accept;
    idle(3);
    chk("t5_err_cnt", 64'(err_cnt), 64'd3);
    chk("t5_valid_cnt", 64'(valid_cnt), 64'd5);
    chk("t5_latency", 64'(last_valid_cyc), 64'(lt));

    // Reset mid-frame at beat 10
    beat(1'b0, hdr_w(10'h222, 2'b10, 2'b11));
    for (int k = 1; k <= 9; k++) beat(1'b0, pay_w(2'b11, slice(va, k)));
    tvalid = 1'b0;
    tlast  = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    chk_outputs_zero("t6_in_reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(vd, 10'h1E1, 2'b01, 2'b11);
    idle(3);
    chk("t6_err_cnt", 64'(err_cnt), 64'd3);
    chk("t6_valid_cnt", 64'(valid_cnt), 64'd6);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
